// File: rtl/div_operand_feeder_if.sv
// Handshake bundle of the divider operand feeder: pair input stream, split x/y dispatch and status.
// The master view belongs to the feeder; the slave view belongs to its surroundings.
interface div_operand_feeder_if #(
    parameter int width = 64,
    parameter int depth = 4
);
    localparam int CW = $clog2(depth) + 1;

    logic [width-1:0] in_x;
    logic [width-1:0] in_y;
    logic             in_vld;
    logic             in_rdy;
    logic [width-1:0] x;
    logic [width-1:0] y;
    logic             data_x_vld;
    logic             data_x_rdy;
    logic             data_y_vld;
    logic             data_y_rdy;
    logic             dz_err;
    logic [CW-1:0]    count;

    modport master (
        input  in_x, in_y, in_vld, data_x_rdy, data_y_rdy,
        output in_rdy, x, y, data_x_vld, data_y_vld, dz_err, count
    );

    modport slave (
        output in_x, in_y, in_vld, data_x_rdy, data_y_rdy,
        input  in_rdy, x, y, data_x_vld, data_y_vld, dz_err, count
    );
endinterface

// File: rtl/div_operand_feeder.sv
// Buffers (dividend, divisor) pairs and hands the head to the divider's independent x/y handshakes;
// zero-divisor pairs are dropped without dispatch and reported on dz_err.
module div_operand_feeder #(
    parameter int width = 64,
    parameter int depth = 4
) (
    input  logic                clk,
    input  logic                asyn_reset_n,
    div_operand_feeder_if.master bus
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0]   L_FULL    = (AW+1)'(depth);
    localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1'b1);
    localparam logic [AW:0]   L_CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW-1:0] L_PTR_ONE = AW'(1'b1);
    localparam logic [AW-1:0] L_PTR_ZERO = {AW{1'b0}};

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    typedef struct packed {
        logic [width-1:0] x;
        logic [width-1:0] y;
    } pair_t;

    pair_t         r_mem [depth];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_sent_x;
    logic          r_sent_y;
    logic          r_dz_err;
    logic          r_in_rdy;
    state_t        r_state;

    pair_t         w_head;
    logic          w_head_valid;
    logic          w_y_zero;
    logic          w_x_vld;
    logic          w_y_vld;
    logic          w_x_hs;
    logic          w_y_hs;
    logic          w_push;
    logic          w_pop_ok;
    logic          w_pop_dz;
    logic          w_pop;
    logic [AW:0]   w_count_next;

    // ISSUE state is the "FIFO non-empty" flag, so the head is only trusted in ISSUE.
    assign w_head       = r_mem[r_rp];
    assign w_head_valid = (r_state == ISSUE);
    assign w_y_zero     = (w_head.y == {width{1'b0}});
    assign w_x_vld      = w_head_valid && !r_sent_x && !w_y_zero;
    assign w_y_vld      = w_head_valid && !r_sent_y && !w_y_zero;
    assign w_x_hs       = w_x_vld && bus.data_x_rdy;
    assign w_y_hs       = w_y_vld && bus.data_y_rdy;
    assign w_push       = bus.in_vld && r_in_rdy;
    assign w_pop_ok     = w_head_valid && !w_y_zero && (r_sent_x || w_x_hs) && (r_sent_y || w_y_hs);
    assign w_pop_dz     = w_head_valid && w_y_zero;
    assign w_pop        = w_pop_ok || w_pop_dz;

    assign bus.x          = w_head.x;
    assign bus.y          = w_head.y;
    assign bus.data_x_vld = w_x_vld;
    assign bus.data_y_vld = w_y_vld;
    assign bus.in_rdy     = r_in_rdy;
    assign bus.dz_err     = r_dz_err;
    assign bus.count      = r_count;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + L_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - L_CNT_ONE;
        end else begin
            w_count_next = r_count;
        end
    end

    // Pair storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= pair_t'{x: bus.in_x, y: bus.in_y};
        end
    end

    // Dispatch FSM with pointers, occupancy, per-side sent flags and registered status outputs.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            r_state  <= IDLE;
            r_wp     <= L_PTR_ZERO;
            r_rp     <= L_PTR_ZERO;
            r_count  <= L_CNT_ZERO;
            r_sent_x <= 1'b0;
            r_sent_y <= 1'b0;
            r_dz_err <= 1'b0;
            r_in_rdy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_count_next != L_CNT_ZERO) begin
                        r_state <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (w_count_next == L_CNT_ZERO) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_push) begin
                r_wp <= r_wp + L_PTR_ONE;
            end else begin
                r_wp <= r_wp;
            end

            if (w_pop) begin
                r_rp     <= r_rp + L_PTR_ONE;
                r_sent_x <= 1'b0;
                r_sent_y <= 1'b0;
            end else begin
                r_rp     <= r_rp;
                r_sent_x <= r_sent_x || w_x_hs;
                r_sent_y <= r_sent_y || w_y_hs;
            end

            r_count  <= w_count_next;
            r_in_rdy <= (w_count_next < L_FULL);
            r_dz_err <= w_pop_dz;
        end
    end
endmodule

// File: tb/tb_div_operand_feeder.sv
// Scenario bench for div_operand_feeder: cycle-level checks plus an in-order scoreboard of dispatched pairs.
module tb_div_operand_feeder;
    logic clk;
    logic rst_n;

    div_operand_feeder_if #(.width(64), .depth(4)) bus ();

    div_operand_feeder #(.width(64), .depth(4)) dut (
        .clk          (clk),
        .asyn_reset_n (rst_n),
        .bus          (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_dz   = 0;
    int dz_cnt   = 0;
    logic [127:0] exp_q [$];
    logic [63:0]  obs_x_q [$];
    logic [63:0]  obs_y_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted side and every dz pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_x_vld && bus.data_x_rdy) obs_x_q.push_back(bus.x);
            if (bus.data_y_vld && bus.data_y_rdy) obs_y_q.push_back(bus.y);
            if (bus.dz_err) dz_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [63:0] px, input logic [63:0] py);
        int n;
        bus.in_x = px;
        bus.in_y = py;
        bus.in_vld = 1'b1;
        n = 0;
        while (!bus.in_rdy && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (!bus.in_rdy) begin
            n_fail++;
            $display("FAIL push_wait: in_rdy got %0b expected 1 within 100 cycles", bus.in_rdy);
        end else if (py != 64'd0) begin
            exp_q.push_back({px, py});
        end else begin
            exp_dz++;
        end
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        logic [127:0] e;
        logic [63:0] ox;
        logic [63:0] oy;
        n = 0;
        while (bus.count != 3'd0 && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus.count !== 3'd0) begin
            n_fail++; $display("FAIL %s_drain: count got %0d expected 0", tag, bus.count);
        end
        n_checks++;
        if (obs_x_q.size() != exp_q.size() || obs_y_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_sb_size: x/y accepted got %0d/%0d expected %0d", tag, obs_x_q.size(), obs_y_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ox = (obs_x_q.size() > 0) ? obs_x_q.pop_front() : 64'hx;
            oy = (obs_y_q.size() > 0) ? obs_y_q.pop_front() : 64'hx;
            n_checks++;
            if (ox !== e[127:64] || oy !== e[63:0]) begin
                n_fail++;
                $display("FAIL %s_sb_pair: got x=%0d y=%0d expected x=%0d y=%0d", tag, ox, oy, e[127:64], e[63:0]);
            end
        end
        obs_x_q.delete();
        obs_y_q.delete();
        n_checks++;
        if (dz_cnt != exp_dz) begin
            n_fail++; $display("FAIL %s_dz_count: got %0d expected %0d", tag, dz_cnt, exp_dz);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.count !== 3'd0 || bus.in_rdy !== 1'b0 || bus.dz_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: count=%0d in_rdy=%0b dz=%0b expected 0/0/0", bus.count, bus.in_rdy, bus.dz_err);
        end
        n_checks++;
        if (bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_vld: got %0b%0b expected 00", bus.data_x_vld, bus.data_y_vld);
        end
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_rdy !== 1'b0) begin
            n_fail++; $display("FAIL reset_rdy_first: got %0b expected 0", bus.in_rdy);
        end
        tick();
        n_checks++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_rdy_second: got %0b expected 1", bus.in_rdy);
        end
    endtask

    task automatic test_single;
        bus.data_x_rdy = 1'b1;
        bus.data_y_rdy = 1'b1;
        push_pair(64'd100, 64'd7);
        n_checks++;
        if (bus.data_x_vld !== 1'b1 || bus.data_y_vld !== 1'b1 || bus.x !== 64'd100 || bus.y !== 64'd7 || bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_head: vld=%0b%0b x=%0d y=%0d count=%0d expected 11/100/7/1", bus.data_x_vld, bus.data_y_vld, bus.x, bus.y, bus.count);
        end
        tick();
        n_checks++;
        if (bus.count !== 3'd0 || bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b0) begin
            n_fail++; $display("FAIL single_retire: count=%0d vld=%0b%0b expected 0/00", bus.count, bus.data_x_vld, bus.data_y_vld);
        end
        drain("single");
    endtask

    task automatic test_split;
        bus.data_x_rdy = 1'b0;
        bus.data_y_rdy = 1'b0;
        push_pair(64'd9, 64'd3);
        n_checks++;
        if (bus.data_x_vld !== 1'b1 || bus.data_y_vld !== 1'b1) begin
            n_fail++; $display("FAIL split_head: vld got %0b%0b expected 11", bus.data_x_vld, bus.data_y_vld);
        end
        bus.data_x_rdy = 1'b1;
        tick();
        bus.data_x_rdy = 1'b0;
        n_checks++;
        if (bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b1 || bus.count !== 3'd1) begin
            n_fail++; $display("FAIL split_x_taken: vld=%0b%0b count=%0d expected 01/1", bus.data_x_vld, bus.data_y_vld, bus.count);
        end
        repeat (2) tick();
        n_checks++;
        if (bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b1 || bus.y !== 64'd3) begin
            n_fail++; $display("FAIL split_y_wait: vld=%0b%0b y=%0d expected 01/3", bus.data_x_vld, bus.data_y_vld, bus.y);
        end
        bus.data_y_rdy = 1'b1;
        tick();
        bus.data_y_rdy = 1'b0;
        n_checks++;
        if (bus.count !== 3'd0 || bus.data_y_vld !== 1'b0) begin
            n_fail++; $display("FAIL split_retire: count=%0d y_vld=%0b expected 0/0", bus.count, bus.data_y_vld);
        end
        push_pair(64'd50, 64'd5);
        bus.data_y_rdy = 1'b1;
        tick();
        bus.data_y_rdy = 1'b0;
        n_checks++;
        if (bus.data_x_vld !== 1'b1 || bus.data_y_vld !== 1'b0 || bus.x !== 64'd50) begin
            n_fail++; $display("FAIL split_y_first: vld=%0b%0b x=%0d expected 10/50", bus.data_x_vld, bus.data_y_vld, bus.x);
        end
        bus.data_x_rdy = 1'b1;
        tick();
        bus.data_x_rdy = 1'b0;
        n_checks++;
        if (bus.count !== 3'd0) begin
            n_fail++; $display("FAIL split_y_first_retire: count got %0d expected 0", bus.count);
        end
        drain("split");
    endtask

    task automatic test_zero_div;
        bus.data_x_rdy = 1'b1;
        bus.data_y_rdy = 1'b1;
        push_pair(64'd5, 64'd0);
        n_checks++;
        if (bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b0 || bus.count !== 3'd1 || bus.dz_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_head: vld=%0b%0b count=%0d dz=%0b expected 00/1/0", bus.data_x_vld, bus.data_y_vld, bus.count, bus.dz_err);
        end
        push_pair(64'd8, 64'd2);
        n_checks++;
        if (bus.dz_err !== 1'b1 || bus.count !== 3'd1 || bus.data_x_vld !== 1'b1 || bus.x !== 64'd8 || bus.y !== 64'd2) begin
            n_fail++;
            $display("FAIL zero_next: dz=%0b count=%0d x_vld=%0b x=%0d y=%0d expected 1/1/1/8/2", bus.dz_err, bus.count, bus.data_x_vld, bus.x, bus.y);
        end
        tick();
        n_checks++;
        if (bus.dz_err !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL zero_pulse_end: dz=%0b count=%0d expected 0/0", bus.dz_err, bus.count);
        end
        drain("zero");
    endtask

    task automatic test_full_wrap;
        bus.data_x_rdy = 1'b0;
        bus.data_y_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(64'd200 + 64'(i), 64'd10 + 64'(i));
        n_checks++;
        if (bus.count !== 3'd4 || bus.in_rdy !== 1'b0) begin
            n_fail++; $display("FAIL full_state: count=%0d in_rdy=%0b expected 4/0", bus.count, bus.in_rdy);
        end
        bus.data_x_rdy = 1'b1;
        bus.data_y_rdy = 1'b1;
        tick();
        n_checks++;
        if (bus.count !== 3'd3 || bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL full_release: count=%0d in_rdy=%0b expected 3/1", bus.count, bus.in_rdy);
        end
        for (int i = 4; i < 8; i++) push_pair(64'd200 + 64'(i), 64'd10 + 64'(i));
        drain("wrap");
    endtask

    task automatic test_mid_reset;
        bus.data_x_rdy = 1'b0;
        bus.data_y_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(64'd300 + 64'(i), 64'd30 + 64'(i));
        bus.data_x_rdy = 1'b1;
        tick();
        bus.data_x_rdy = 1'b0;
        n_checks++;
        if (bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b1 || bus.count !== 3'd3) begin
            n_fail++; $display("FAIL midrst_pre: vld=%0b%0b count=%0d expected 01/3", bus.data_x_vld, bus.data_y_vld, bus.count);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.data_x_vld !== 1'b0 || bus.data_y_vld !== 1'b0 || bus.in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: count=%0d vld=%0b%0b in_rdy=%0b expected 0/00/0", bus.count, bus.data_x_vld, bus.data_y_vld, bus.in_rdy);
        end
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        obs_x_q.delete();
        obs_y_q.delete();
        n_checks++;
        if (bus.in_rdy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_rdy_first: got %0b expected 0", bus.in_rdy);
        end
        tick();
        n_checks++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_rdy_second: got %0b expected 1", bus.in_rdy);
        end
        bus.data_x_rdy = 1'b1;
        bus.data_y_rdy = 1'b1;
        push_pair(64'd12, 64'd4);
        n_checks++;
        if (bus.data_x_vld !== 1'b1 || bus.x !== 64'd12 || bus.y !== 64'd4 || bus.count !== 3'd1) begin
            n_fail++; $display("FAIL midrst_fresh: x_vld=%0b x=%0d y=%0d count=%0d expected 1/12/4/1", bus.data_x_vld, bus.x, bus.y, bus.count);
        end
        drain("midrst");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_x = 64'd0;
        bus.in_y = 64'd0;
        bus.in_vld = 1'b0;
        bus.data_x_rdy = 1'b0;
        bus.data_y_rdy = 1'b0;
        test_reset();
        test_single();
        test_split();
        test_zero_div();
        test_full_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
